cnn_sdiv_23s_9u_seq: RTL and testbench
======================================

CNN_SDIV_23S_9U_SEQ -- requirements
Module: cnn_sdiv_23s_9u_seq

Interface
REQ-001 SHALL have parameters: ID, default 1, instance tag with no functional effect; din0_WIDTH, default 23, dividend width; din1_WIDTH, default 9, divisor width; dout_WIDTH, default 23, quotient width.
REQ-002 SHALL have ports (name direction width meaning):
- ap_clk  in  1  single clock, rising edge.
- ap_rst_n  in  1  reset, asynchronous and active-low.
- ap_start  in  1  request a division.
- ap_ready  out  1  operands captured this cycle.
- ap_idle  out  1  block is in IDLE.
- ap_done  out  1  results valid, one-cycle pulse.
- din0  in  din0_WIDTH  signed dividend.
- din1  in  din1_WIDTH  unsigned divisor.
- dout_q  out  dout_WIDTH  signed quotient.
- dout_r  out  din1_WIDTH+1  signed remainder.
- div_by_zero  out  1  last operation had din1 equal to 0.

Function
REQ-003 SHALL implement four states: IDLE, CALC, FIX and DONE.
REQ-004 In IDLE with ap_start=1, SHALL capture din0 and din1, drive ap_ready=1 combinationally in that cycle, and go to CALC.
REQ-005 SHALL ignore ap_start in CALC, FIX and DONE; ap_ready SHALL be 0 in those states.
REQ-006 CALC SHALL run a radix-2 restoring division of |din0| by din1, one quotient bit per cycle, MSB first.
- CALC SHALL last exactly din0_WIDTH cycles (23 at default), counted by an internal iteration counter.
REQ-007 FIX SHALL last one cycle and do the following:
- negate the quotient magnitude when din0 < 0;
- give the remainder the sign of din0, so quotient truncates toward zero and din0 = q*din1 + r.
REQ-008 DONE SHALL last one cycle with ap_done=1, then return to IDLE.
REQ-009 Latency: ap_done SHALL be high exactly din0_WIDTH+2 cycles after the ap_start-accept edge (25 at default), independent of the operand values.
REQ-010 dout_q, dout_r and div_by_zero SHALL update only on the FIX-to-DONE edge and SHALL hold stable until the next DONE.
REQ-011 ap_idle SHALL be 1 only in IDLE; ap_idle and ap_done SHALL never both be 1.
REQ-012 Back-to-back: ap_start=1 in the cycle after DONE (now IDLE) SHALL be accepted, giving one result every 26 cycles.
REQ-013 din0 = -2^(din0_WIDTH-1) SHALL be handled without overflow: the internal magnitude is din0_WIDTH bits unsigned.
REQ-014 Divide by zero (din1=0) SHALL keep the same latency and produce:
- dout_q = +max (23'h3FFFFF) if din0 >= 0, else -max-1 (23'h400000);
- dout_r = 0;
- div_by_zero = 1.
REQ-015 div_by_zero SHALL be 0 for every result with din1 != 0.
REQ-016 Changes on din0 and din1 after the accept edge SHALL NOT affect the result.

Reset
REQ-017 ap_rst_n=0 SHALL asynchronously force all of the following, regardless of state:
- state=IDLE, iteration counter=0;
- ap_done=0, ap_ready=0, ap_idle=1;
- dout_q=0, dout_r=0, div_by_zero=0.
REQ-018 Reset asserted mid-CALC SHALL abort the operation; no ap_done pulse SHALL follow.
REQ-019 After ap_rst_n rises, the first ap_start SHALL be accepted on the next rising edge.

Verification
REQ-020 din0=100, din1=7 -> ap_done 25 cycles after accept; dout_q=14, dout_r=2, div_by_zero=0.
REQ-021 din0=-100, din1=7 -> dout_q=-14, dout_r=-2; din0=4194303, din1=511 -> dout_q=8208, dout_r=15.
REQ-022 din0=-4194304, din1=1 -> dout_q=-4194304, dout_r=0; din0=-5, din1=9 -> dout_q=0, dout_r=-5.
REQ-023 din0=1234, din1=0 -> dout_q=23'h3FFFFF, dout_r=0, div_by_zero=1; din0=-1, din1=0 -> dout_q=23'h400000.
REQ-024 Protocol and inputs: hold ap_start=1 continuously while toggling din0 and din1 during CALC.
- ap_ready pulses only in IDLE;
- results every 26 cycles match the operands captured at accept;
- ap_idle/ap_done are never both 1.
REQ-025 Assert ap_rst_n=0 at CALC cycle 10 -> all outputs 0 and ap_idle=1 immediately; no ap_done follows; the next division completes correctly.

Source files
------------

// File: rtl/cnn_sdiv_23s_9u_seq.sv
// Sequential signed/unsigned divider: radix-2 restoring division of |din0| by din1,
// one quotient bit per cycle, followed by a sign-fix cycle and a one-cycle done pulse.
module cnn_sdiv_23s_9u_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 23,
    parameter int din1_WIDTH = 9,
    parameter int dout_WIDTH = 23
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout_q,
    output logic [din1_WIDTH:0]   dout_r,
    output logic                  div_by_zero
);
    localparam int W  = din0_WIDTH;
    localparam int D  = din1_WIDTH;
    localparam int RW = D + 1;
    localparam int CW = $clog2(W) + 1;

    localparam logic [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};

    // ID is only an instance tag; it has no effect on the logic.
    if (ID < 0) begin : g_id_tag
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    mag_q, mag_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [D-1:0]    div_q, div_d;
    logic            neg_q, neg_d;
    logic            zero_q, zero_d;
    logic            done_q, done_d;
    logic            idle_q, idle_d;
    logic [dout_WIDTH-1:0] dout_q_q, dout_q_d;
    logic [RW-1:0]   dout_r_q, dout_r_d;
    logic            dbz_q, dbz_d;

    logic            accept;
    logic [RW-1:0]   rem_shift;
    logic [RW-1:0]   rem_sub;
    logic            rem_ge;
    logic [W-1:0]    q_fix;
    logic [RW-1:0]   r_fix;

    assign accept = (state_q == S_IDLE) && ap_start && ap_rst_n;

    // mag_q doubles as dividend shift-out and quotient shift-in register.
    assign rem_shift = {rem_q[D-1:0], mag_q[W-1]};
    assign rem_ge    = rem_shift >= {1'b0, div_q};
    assign rem_sub   = rem_shift - {1'b0, div_q};

    always_comb begin
        if (zero_q) begin
            q_fix = neg_q ? Q_MIN : Q_MAX;
            r_fix = '0;
        end else begin
            q_fix = neg_q ? ((~mag_q) + W'(1)) : mag_q;
            r_fix = neg_q ? ((~rem_q) + RW'(1)) : rem_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mag_d    = mag_q;
        rem_d    = rem_q;
        div_d    = div_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        done_d   = done_q;
        idle_d   = idle_q;
        dout_q_d = dout_q_q;
        dout_r_d = dout_r_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mag_d   = din0[W-1] ? ((~din0) + W'(1)) : din0;
                    neg_d   = din0[W-1];
                    div_d   = din1;
                    zero_d  = (din1 == '0);
                    rem_d   = '0;
                    cnt_d   = '0;
                    idle_d  = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                rem_d = rem_ge ? rem_sub : rem_shift;
                mag_d = {mag_q[W-2:0], rem_ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                dout_q_d = dout_WIDTH'(q_fix);
                dout_r_d = r_fix;
                dbz_d    = zero_q;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b0;
                idle_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idle_d  = 1'b1;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mag_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            idle_q   <= 1'b1;
            dout_q_q <= '0;
            dout_r_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mag_q    <= mag_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            idle_q   <= idle_d;
            dout_q_q <= dout_q_d;
            dout_r_q <= dout_r_d;
            dbz_q    <= dbz_d;
        end
    end

    assign ap_ready    = accept;
    assign ap_idle     = idle_q;
    assign ap_done     = done_q;
    assign dout_q      = dout_q_q;
    assign dout_r      = dout_r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_cnn_sdiv_23s_9u_seq.sv
// Directed bench for cnn_sdiv_23s_9u_seq: arithmetic vectors, divide-by-zero,
// back-to-back protocol with changing operands, and reset abort mid-calculation.
module tb_cnn_sdiv_23s_9u_seq;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_ready;
    logic        ap_idle;
    logic        ap_done;
    logic [22:0] din0 = '0;
    logic [8:0]  din1 = '0;
    logic [22:0] dout_q;
    logic [9:0]  dout_r;
    logic        div_by_zero;

    int total = 0;
    int bad = 0;

    cnn_sdiv_23s_9u_seq #(
        .ID(1), .din0_WIDTH(23), .din1_WIDTH(9), .dout_WIDTH(23)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_done(ap_done),
        .din0(din0), .din1(din1), .dout_q(dout_q), .dout_r(dout_r),
        .div_by_zero(div_by_zero)
    );

    always #5 ap_clk = ~ap_clk;

    // Issue one division and watch for done; operands are scrambled after the accept edge.
    // lat is the cycle index of ap_done counting the accept cycle as 0 (-1 on timeout).
    task automatic run_div(input int a, input int b, output logic [22:0] q, output logic [9:0] r,
                           output logic z, output int lat, output bit rdy, output bit held);
        logic [22:0] q0;
        logic [9:0]  r0;
        logic        z0;
        lat = -1; held = 1'b1; q = '0; r = '0; z = 1'b0;
        @(negedge ap_clk);
        din0 = 23'(a); din1 = 9'(b); ap_start = 1'b1;
        #1 rdy = ap_ready;
        q0 = dout_q; r0 = dout_r; z0 = div_by_zero;
        for (int k = 1; k <= 40; k++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                lat = k; q = dout_q; r = dout_r; z = div_by_zero;
                break;
            end
            if (dout_q !== q0 || dout_r !== r0 || div_by_zero !== z0) held = 1'b0;
            ap_start = 1'b0;
            din0 = 23'($urandom); din1 = 9'($urandom);
        end
    endtask

    task automatic test_reset();
        ap_start = 1'b1;
        repeat (2) @(negedge ap_clk);
        total++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl idle=%b done=%b ready=%b want 1 0 0", ap_idle, ap_done, ap_ready);
        end
        total++;
        if (dout_q !== 23'd0 || dout_r !== 10'd0 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_data q=%h r=%h dbz=%b want 0 0 0", dout_q, dout_r, div_by_zero);
        end
        ap_start = 1'b0;
        ap_rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        int va[7] = '{100, -100, 4194303, -4194304, -5, 7, -7};
        int vb[7] = '{7, 7, 511, 1, 9, 100, 2};
        int vq[7] = '{14, -14, 8208, -4194304, 0, 0, -3};
        int vr[7] = '{2, -2, 15, 0, -5, 7, -1};
        logic [22:0] q, eq;
        logic [9:0]  r, er;
        logic        z;
        int          lat;
        bit          rdy, held;
        for (int i = 0; i < 7; i++) begin
            eq = 23'(vq[i]); er = 10'(vr[i]);
            run_div(va[i], vb[i], q, r, z, lat, rdy, held);
            total++;
            if (rdy !== 1'b1) begin bad++; $display("FAIL vec%0d_ready got=%b want=1", i, rdy); end
            total++;
            if (lat != 25) begin bad++; $display("FAIL vec%0d_latency got=%0d want=25", i, lat); end
            total++;
            if (q !== eq) begin bad++; $display("FAIL vec%0d_quot got=%h want=%h", i, q, eq); end
            total++;
            if (r !== er) begin bad++; $display("FAIL vec%0d_rem got=%h want=%h", i, r, er); end
            total++;
            if (z !== 1'b0) begin bad++; $display("FAIL vec%0d_dbz got=%b want=0", i, z); end
            total++;
            if (held !== 1'b1) begin bad++; $display("FAIL vec%0d_hold outputs changed before done", i); end
        end
    endtask

    task automatic test_div_zero();
        int va[3] = '{1234, -1, 0};
        logic [22:0] eqs[3] = '{23'h3FFFFF, 23'h400000, 23'h3FFFFF};
        logic [22:0] q;
        logic [9:0]  r;
        logic        z;
        int          lat;
        bit          rdy, held;
        for (int i = 0; i < 3; i++) begin
            run_div(va[i], 0, q, r, z, lat, rdy, held);
            total++;
            if (lat != 25) begin bad++; $display("FAIL dz%0d_latency got=%0d want=25", i, lat); end
            total++;
            if (q !== eqs[i]) begin bad++; $display("FAIL dz%0d_quot got=%h want=%h", i, q, eqs[i]); end
            total++;
            if (r !== 10'd0) begin bad++; $display("FAIL dz%0d_rem got=%h want=0", i, r); end
            total++;
            if (z !== 1'b1) begin bad++; $display("FAIL dz%0d_dbz got=%b want=1", i, z); end
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [22:0] q;
        logic [9:0]  r;
        logic        z;
        int          lat, spurious;
        bit          rdy, held;
        @(negedge ap_clk);
        din0 = 23'd1000; din1 = 9'd3; ap_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
        end
        ap_rst_n = 1'b0; ap_start = 1'b1;
        #1;
        total++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_ctrl idle=%b done=%b ready=%b want 1 0 0", ap_idle, ap_done, ap_ready);
        end
        total++;
        if (dout_q !== 23'd0 || dout_r !== 10'd0 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL abort_data q=%h r=%h dbz=%b want 0 0 0", dout_q, dout_r, div_by_zero);
        end
        repeat (2) @(negedge ap_clk);
        ap_start = 1'b0; ap_rst_n = 1'b1;
        spurious = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge ap_clk);
            if (ap_done) spurious++;
        end
        total++;
        if (spurious != 0) begin bad++; $display("FAIL abort_no_done got=%0d pulses want=0", spurious); end
        run_div(1000, 3, q, r, z, lat, rdy, held);
        total++;
        if (lat != 25 || q !== 23'd333 || r !== 10'd1 || z !== 1'b0) begin
            bad++;
            $display("FAIL abort_recover lat=%0d q=%h r=%h dbz=%b want 25 14d 001 0", lat, q, r, z);
        end
    endtask

    task automatic test_back_to_back();
        int va[3] = '{100, -4194304, 4194303};
        int vb[3] = '{7, 3, 511};
        int vq[3] = '{14, -1398101, 8208};
        int vr[3] = '{2, -1, 15};
        int ready_bad, both_bad, early_done;
        ready_bad = 0; both_bad = 0; early_done = 0;
        ap_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            din0 = 23'(va[i]); din1 = 9'(vb[i]);
            #1;
            total++;
            if (ap_ready !== 1'b1 || ap_idle !== 1'b1) begin
                bad++;
                $display("FAIL b2b%0d_accept ready=%b idle=%b want 1 1", i, ap_ready, ap_idle);
            end
            for (int k = 1; k <= 25; k++) begin
                @(negedge ap_clk);
                if (ap_ready !== 1'b0) ready_bad++;
                if (ap_idle === 1'b1 && ap_done === 1'b1) both_bad++;
                if (k < 25 && ap_done !== 1'b0) early_done++;
                if (k == 25) begin
                    total++;
                    if (ap_done !== 1'b1 || dout_q !== 23'(vq[i]) || dout_r !== 10'(vr[i])) begin
                        bad++;
                        $display("FAIL b2b%0d_result done=%b q=%h r=%h want 1 %h %h", i, ap_done,
                                 dout_q, dout_r, 23'(vq[i]), 10'(vr[i]));
                    end
                end
                din0 = 23'($urandom); din1 = 9'($urandom);
            end
        end
        ap_start = 1'b0;
        total++;
        if (ready_bad != 0) begin bad++; $display("FAIL b2b_ready_busy got=%0d want=0", ready_bad); end
        total++;
        if (both_bad != 0) begin bad++; $display("FAIL b2b_idle_done got=%0d want=0", both_bad); end
        total++;
        if (early_done != 0) begin bad++; $display("FAIL b2b_early_done got=%0d want=0", early_done); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_div_zero();
        test_reset_mid_calc();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
